// File: rtl/conv_fp_pkg.sv
// Shared widths and types for the FP16 convolution product datapath.
package conv_fp_pkg;
  localparam int EXP_SIZE    = 5;
  localparam int MANT_SIZE   = 10;
  localparam int KERNEL_SIZE = 3;
  localparam int PEXP_W      = EXP_SIZE + 1;
  localparam int PM_W        = 2 * MANT_SIZE;
  localparam int N           = KERNEL_SIZE * KERNEL_SIZE;

  typedef struct packed {
    logic              sign;
    logic [PEXP_W-1:0] exp;
    logic [PM_W-1:0]   mant;
  } prod_t;

  typedef logic signed [PM_W:0] aligned_t;
endpackage

// File: rtl/conv_max_exp.sv
// Combinational maximum over the exponents of the nonzero lanes; 0 when every lane is zero.
module conv_max_exp #(
  parameter int N = 9,
  parameter int W = 6
) (
  input  logic [N*W-1:0] exp_flat,
  input  logic [N-1:0]   zero,
  output logic [W-1:0]   emax
);
  always_comb begin
    emax = '0;
    for (int i = 0; i < N; i++) begin
      if (!zero[i] && (exp_flat[i*W +: W] > emax)) emax = exp_flat[i*W +: W];
    end
  end
endmodule

// File: rtl/conv_prod_align.sv
// Aligns the N products of one convolution window to their common maximum exponent and
// emits each lane as a signed two's-complement mantissa; 3-stage valid/ready pipeline.
module conv_prod_align #(
  parameter int EXP_SIZE    = conv_fp_pkg::EXP_SIZE,
  parameter int MANT_SIZE   = conv_fp_pkg::MANT_SIZE,
  parameter int KERNEL_SIZE = conv_fp_pkg::KERNEL_SIZE,
  localparam int PEXP_W     = EXP_SIZE + 1,
  localparam int PM_W       = 2 * MANT_SIZE,
  localparam int N          = KERNEL_SIZE * KERNEL_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          in_sign,
  input  logic [N*PEXP_W-1:0]   in_exp,
  input  logic [N*PM_W-1:0]     in_mant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PEXP_W-1:0]     out_exp,
  output logic [N*(PM_W+1)-1:0] out_mant
);
  localparam int OW = PM_W + 1;

  logic                adv;
  logic [N-1:0]        zero_next;
  logic [PEXP_W-1:0]   emax_next;
  logic [N*PM_W-1:0]   mag_next;
  logic [N*OW-1:0]     lane_next;

  logic                s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic [PEXP_W-1:0]   s1_emax_reg, s2_emax_reg, s3_emax_reg;
  logic [N-1:0]        s1_sign_reg, s2_sign_reg, s1_zero_reg;
  logic [N*PEXP_W-1:0] s1_exp_reg;
  logic [N*PM_W-1:0]   s1_mant_reg, s2_mag_reg;
  logic [N*OW-1:0]     s3_mant_reg;

  // The whole pipeline stalls only when a finished window is waiting on the output.
  assign adv       = out_ready | ~s3_valid_reg;
  assign in_ready  = adv;
  assign out_valid = s3_valid_reg;
  assign out_exp   = s3_emax_reg;
  assign out_mant  = s3_mant_reg;

  conv_max_exp #(.N(N), .W(PEXP_W)) u_max_exp (
    .exp_flat (in_exp),
    .zero     (zero_next),
    .emax     (emax_next)
  );

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [PEXP_W-1:0] sh;
      logic [PM_W-1:0]   mag;
      logic [OW-1:0]     pos;

      assign zero_next[gi] = (in_mant[gi*PM_W +: PM_W] == '0);

      // Wrapped shifts on zero lanes are harmless: the zero flag forces the result to 0.
      assign sh = s1_emax_reg - s1_exp_reg[gi*PEXP_W +: PEXP_W];
      assign mag_next[gi*PM_W +: PM_W] =
          (s1_zero_reg[gi] || (32'(sh) >= PM_W)) ? '0 : (s1_mant_reg[gi*PM_W +: PM_W] >> sh);

      assign mag = s2_mag_reg[gi*PM_W +: PM_W];
      assign pos = {1'b0, mag};
      assign lane_next[gi*OW +: OW] = s2_sign_reg[gi] ? (~pos + OW'(1)) : pos;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_emax_reg  <= '0;
      s1_sign_reg  <= '0;
      s1_zero_reg  <= '0;
      s1_exp_reg   <= '0;
      s1_mant_reg  <= '0;
      s2_valid_reg <= 1'b0;
      s2_emax_reg  <= '0;
      s2_sign_reg  <= '0;
      s2_mag_reg   <= '0;
      s3_valid_reg <= 1'b0;
      s3_emax_reg  <= '0;
      s3_mant_reg  <= '0;
    end else if (adv) begin
      s1_valid_reg <= in_valid;
      s1_emax_reg  <= emax_next;
      s1_sign_reg  <= in_sign;
      s1_zero_reg  <= zero_next;
      s1_exp_reg   <= in_exp;
      s1_mant_reg  <= in_mant;
      s2_valid_reg <= s1_valid_reg;
      s2_emax_reg  <= s1_emax_reg;
      s2_sign_reg  <= s1_sign_reg;
      s2_mag_reg   <= mag_next;
      s3_valid_reg <= s2_valid_reg;
      s3_emax_reg  <= s2_emax_reg;
      s3_mant_reg  <= lane_next;
    end
  end
endmodule
